// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 scancode receiver.
//   ps2_state_t : frame receiver FSM states
//   PS2_EXT/BRK : prefix bytes folded into entry flags
//   ps2_code_t  : FIFO entry {ext, brk, code}
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_code_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word-fall-through head.
//   clk, reset     : clock, synchronous active-high reset
//   push/push_data : write request and data (ignored when full unless popping)
//   pop            : read request (ignored when empty)
//   full/empty     : occupancy flags
//   head           : entry at the read pointer
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written when full.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver in the system clock domain: synchronise and filter
// the pins, decode 11-bit frames, fold E0/F0 prefixes into flags and queue
// scancodes behind a valid/ready interface.
//   clk, reset          : system clock, synchronous active-high reset
//   ps2_clk, ps2_data   : raw asynchronous PS/2 pins
//   out_code/ext/brk    : FIFO head entry
//   out_valid/out_ready : consumer handshake
//   err_frame           : pulse on parity/stop error
//   err_timeout         : pulse on abandoned partial frame
//   overflow            : pulse when a code is dropped on a full FIFO
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] out_code,
  output logic       out_ext,
  output logic       out_brk,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       overflow
);

  localparam int unsigned FC_W = $clog2(FILTER_LEN);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic [FC_W-1:0] clk_fcnt;
  logic [FC_W-1:0] data_fcnt;
  logic            clk_filt;
  logic            clk_filt_q;
  logic            data_filt;
  logic            strobe_c;

  ps2_state_t      state;
  ps2_state_t      state_d;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [TO_W-1:0] to_cnt;
  logic            ext_pend;
  logic            brk_pend;
  logic            frame_end_c;
  logic            frame_good_c;
  logic            timeout_c;

  logic            push_c;
  logic            pop_c;
  logic            fifo_full;
  logic            fifo_empty;
  ps2_code_t       push_entry;
  ps2_code_t       head_entry;

  // Two-flop synchronisers, idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Deglitch: a level is accepted after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      clk_fcnt   <= '0;
      data_filt  <= 1'b1;
      data_fcnt  <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FC_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + FC_W'(1);
      end
      if (data_sync[1] == data_filt) begin
        data_fcnt <= '0;
      end else if (data_fcnt == FC_W'(FILTER_LEN - 1)) begin
        data_filt <= data_sync[1];
        data_fcnt <= '0;
      end else begin
        data_fcnt <= data_fcnt + FC_W'(1);
      end
    end
  end

  assign strobe_c = clk_filt_q & ~clk_filt;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // FSM next state and frame verdict; a strobe takes precedence over timeout.
  always_comb begin
    state_d      = state;
    frame_end_c  = 1'b0;
    frame_good_c = 1'b0;
    timeout_c    = 1'b0;
    if (strobe_c) begin
      case (state)
        IDLE:    if (!data_filt) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d      = IDLE;
          frame_end_c  = 1'b1;
          frame_good_c = data_filt & ((^shift_q) ^ parity_q);
        end
        default: state_d = IDLE;
      endcase
    end else if ((state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES))) begin
      state_d   = IDLE;
      timeout_c = 1'b1;
    end
  end

  assign push_c = frame_end_c & frame_good_c &
                  (shift_q != PS2_EXT) & (shift_q != PS2_BRK);
  assign pop_c  = ~fifo_empty & out_ready;
  assign push_entry = {ext_pend, brk_pend, shift_q};

  // Frame datapath, timeout counter, prefix flags and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt      <= '0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      err_frame   <= frame_end_c & ~frame_good_c;
      err_timeout <= timeout_c;
      overflow    <= push_c & fifo_full & ~pop_c;

      if ((state == IDLE) || strobe_c || timeout_c) to_cnt <= '0;
      else                                          to_cnt <= to_cnt + TO_W'(1);

      if (strobe_c) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift_q <= {data_filt, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  parity_q <= data_filt;
          default: ;
        endcase
      end

      if (frame_end_c && frame_good_c) begin
        if (shift_q == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (shift_q == PS2_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end else if (frame_end_c || timeout_c) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(ps2_code_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (pop_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_entry)
  );

  assign out_valid = ~fifo_empty;
  assign out_code  = head_entry.code;
  assign out_ext   = head_entry.ext;
  assign out_brk   = head_entry.brk;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames, expected
// entries queued by the stimulus and checked by an output monitor.
module tb_ps2_scancode_rx;
  import ps2_pkg::*;

  localparam int unsigned FILTER_LEN     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 300;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int          HALF           = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_brk;
  logic       out_valid;
  logic       out_ready;
  logic       err_frame;
  logic       err_timeout;
  logic       overflow;

  int n_vec = 0;
  int n_fail = 0;
  int n_errf = 0;
  int n_errto = 0;
  int n_ovf = 0;
  int n_pop = 0;
  int valid_cycles = 0;
  logic [9:0] exp_q [$];

  ps2_scancode_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .out_code    (out_code),
    .out_ext     (out_ext),
    .out_brk     (out_brk),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_frame   (err_frame),
    .err_timeout (err_timeout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    logic p;
    p = ~(^b) ^ flip_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    wait_cyc(HALF);
  endtask

  task automatic expect_code(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  // Monitor: pop and compare on every accepted transfer; count pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid)   valid_cycles++;
      if (err_frame)   n_errf++;
      if (err_timeout) n_errto++;
      if (overflow)    n_ovf++;
      if (out_valid && out_ready) begin
        logic [9:0] e;
        n_pop++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pop: got ext=%0b brk=%0b code=%02h, expected nothing",
                   out_ext, out_brk, out_code);
        end else begin
          e = exp_q.pop_front();
          if ({out_ext, out_brk, out_code} !== e) begin
            n_fail++;
            $display("FAIL pop_entry: got ext=%0b brk=%0b code=%02h, expected ext=%0b brk=%0b code=%02h",
                     out_ext, out_brk, out_code, e[9], e[8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    int v0, e0, t0, o0, p0;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b1;
    wait_cyc(5);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_head", {22'd0, out_ext, out_brk, out_code}, 0);
    check("reset_pulses", {29'd0, err_frame, err_timeout, overflow}, 0);
    reset = 1'b0;
    wait_cyc(20);

    // Single code
    v0 = valid_cycles;
    expect_code(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    wait_cyc(10);
    check("single_valid_cycles", 32'(valid_cycles - v0), 1);
    check("single_pops", 32'(n_pop), 1);

    // Prefix folding
    expect_code(1'b1, 1'b1, 8'h75);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    expect_code(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    wait_cyc(10);
    check("prefix_pops", 32'(n_pop), 3);

    // Bad parity, then recovery
    e0 = n_errf;
    send_frame(8'h1C, 1'b1);
    wait_cyc(10);
    check("parity_err_pulses", 32'(n_errf - e0), 1);
    check("parity_no_push", 32'(n_pop), 3);
    expect_code(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);

    // Timeout on a partial frame
    t0 = n_errto; e0 = n_errf;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    wait_cyc(TIMEOUT_CYCLES + 60);
    check("timeout_pulses", 32'(n_errto - t0), 1);
    check("timeout_state_idle", 32'(dut.state), 32'(IDLE));
    check("timeout_no_frame_err", 32'(n_errf - e0), 0);
    expect_code(1'b0, 1'b0, 8'h29);
    send_frame(8'h29, 1'b0);

    // Glitch rejection with data held low
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 2);
    ps2_clk = 1'b1;
    wait_cyc(20);
    check("glitch_state_idle", 32'(dut.state), 32'(IDLE));
    ps2_data = 1'b1;
    wait_cyc(10);
    expect_code(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    wait_cyc(10);
    check("glitch_pops", 32'(n_pop), 6);

    // Overflow with a stalled consumer
    out_ready = 1'b0;
    o0 = n_ovf;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expect_code(1'b0, 1'b0, 8'(i));
      send_frame(8'(i), 1'b0);
    end
    wait_cyc(10);
    check("overflow_pulses", 32'(n_ovf - o0), 1);
    check("stall_valid", 32'(out_valid), 1);
    check("stall_head", {22'd0, out_ext, out_brk, out_code}, 32'h001);
    wait_cyc(7);
    check("stall_head_hold", 32'(out_code), 32'h01);
    p0 = n_pop;
    out_ready = 1'b1;
    wait_cyc(4);
    check("drain_pops", 32'(n_pop - p0), 4);
    check("drain_empty", 32'(out_valid), 0);

    // Reset mid-frame with a queued entry
    out_ready = 1'b0;
    send_frame(8'h29, 1'b0);
    wait_cyc(5);
    check("pre_reset_valid", 32'(out_valid), 1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    e0 = n_errf; t0 = n_errto;
    wait_cyc(TIMEOUT_CYCLES + 50);
    check("reset_mid_valid", 32'(out_valid), 0);
    check("reset_mid_head", {24'd0, out_code}, 0);
    check("reset_mid_errs", 32'((n_errf - e0) + (n_errto - t0)), 0);
    out_ready = 1'b1;
    expect_code(1'b0, 1'b0, 8'h29);
    send_frame(8'h29, 1'b0);
    wait_cyc(10);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
